// File: rtl/set_associative_lru_replacement.sv
// ============================================================================
// Module   : set_associative_lru_replacement
// Brief    : True-LRU age tracking per set with a registered victim-way query.
//            Optional macro REPLACEMENT_WAY_LOCK_EN adds a per-way lock mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_associative_lru_replacement #(
  parameter int NUMBER_OF_WAYS = 4,
  parameter int NUMBER_OF_SETS = 8,
  localparam int WAY_WIDTH = $clog2(NUMBER_OF_WAYS),
  localparam int SET_WIDTH = (NUMBER_OF_SETS == 1) ? 1 : $clog2(NUMBER_OF_SETS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 accessEnable,
  input  logic [SET_WIDTH-1:0] accessSet,
  input  logic [WAY_WIDTH-1:0] lastAccessedCacheLine,
  input  logic                 invalidateEnable,
  input  logic [SET_WIDTH-1:0] invalidateSet,
  input  logic [WAY_WIDTH-1:0] invalidatedCacheLine,
  input  logic [SET_WIDTH-1:0] replacementSet,
  output logic [WAY_WIDTH-1:0] replacementCacheLine
`ifdef REPLACEMENT_WAY_LOCK_EN
  ,
  input  logic [NUMBER_OF_WAYS-1:0] lockMask
`endif
);

  typedef logic [WAY_WIDTH-1:0]                     age_t;
  typedef logic [NUMBER_OF_WAYS-1:0][WAY_WIDTH-1:0] row_t;

  localparam age_t c_LRU_AGE = age_t'(NUMBER_OF_WAYS - 1);

  row_t r_age [NUMBER_OF_SETS];
  row_t w_age_next [NUMBER_OF_SETS];
  row_t w_query_row;
  age_t w_victim;
  age_t r_victim;

  // Promote way a to MRU; every younger way ages by one.
  function automatic row_t promote(input row_t r, input age_t a);
    row_t n;
    age_t ref_age;
    n       = r;
    ref_age = r[a];
    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (r[w] < ref_age) n[w] = r[w] + age_t'(1);
    end
    n[a] = '0;
    return n;
  endfunction

  // Demote way i to LRU; every older way gets one step younger.
  function automatic row_t demote(input row_t r, input age_t i);
    row_t n;
    age_t ref_age;
    n       = r;
    ref_age = r[i];
    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (r[w] > ref_age) n[w] = r[w] - age_t'(1);
    end
    n[i] = c_LRU_AGE;
    return n;
  endfunction

  function automatic age_t lru_way(input row_t r);
    age_t v;
    v = '0;
    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (r[w] == c_LRU_AGE) v = age_t'(w);
    end
    return v;
  endfunction

`ifdef REPLACEMENT_WAY_LOCK_EN
  // Oldest unlocked way; falls back to true LRU when every way is locked.
  function automatic age_t pick_victim(input row_t r, input logic [NUMBER_OF_WAYS-1:0] lk);
    age_t v;
    age_t best;
    logic found;
    v     = lru_way(r);
    best  = '0;
    found = 1'b0;
    for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
      if (!lk[w] && (!found || r[w] > best)) begin
        found = 1'b1;
        best  = r[w];
        v     = age_t'(w);
      end
    end
    return v;
  endfunction
`endif

  // Access is applied before invalidate when both target the same set.
  always_comb begin
    for (int s = 0; s < NUMBER_OF_SETS; s++) begin
      w_age_next[s] = r_age[s];
      if (accessEnable && accessSet == SET_WIDTH'(s))
        w_age_next[s] = promote(w_age_next[s], lastAccessedCacheLine);
      if (invalidateEnable && invalidateSet == SET_WIDTH'(s))
        w_age_next[s] = demote(w_age_next[s], invalidatedCacheLine);
    end
  end

  always_comb begin
    w_query_row = w_age_next[0];
    for (int s = 0; s < NUMBER_OF_SETS; s++) begin
      if (replacementSet == SET_WIDTH'(s)) w_query_row = w_age_next[s];
    end
  end

`ifdef REPLACEMENT_WAY_LOCK_EN
  assign w_victim = pick_victim(w_query_row, lockMask);
`else
  assign w_victim = lru_way(w_query_row);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUMBER_OF_SETS; s++) begin
        for (int w = 0; w < NUMBER_OF_WAYS; w++) begin
          r_age[s][w] <= age_t'(NUMBER_OF_WAYS - 1 - w);
        end
      end
      r_victim <= '0;
    end else begin
      for (int s = 0; s < NUMBER_OF_SETS; s++) begin
        r_age[s] <= w_age_next[s];
      end
      r_victim <= w_victim;
    end
  end

  assign replacementCacheLine = r_victim;

endmodule

`default_nettype wire
